usb_link_ctrl: RTL and testbench
================================

# usb_link_ctrl

USB full-speed link-state controller sitting between the `usb_top` pins (`usb_d_p`, `usb_d_n`, `usb_pullup`) and the SIE. It sequences device attach via the D+ pull-up and detects host bus reset (SE0) and bus suspend (idle J). It also drives remote-wakeup K signalling. It owns the pull-up and arbitrates the line between host-observed states and device-driven resume.

## Interface
Parameters:
- `ATTACH_DELAY`, 4800: cycles in ATTACH_WAIT before pull-up asserts (100 µs @ 48 MHz).
- `RESET_SE0_CYCLES`, 120: consecutive SE0 cycles that qualify a bus reset (2.5 µs).
- `SUSPEND_IDLE_CYCLES`, 144000: consecutive idle-J cycles before suspend (3 ms).
- `WAKEUP_MIN_IDLE`, 240000: minimum idle-J count before remote wakeup is permitted (5 ms).
- `RESUME_K_CYCLES`, 48000: duration of driven K during remote wakeup (1 ms).

Ports:
- `clk48`  in  1  48 MHz system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  attach request; level-sensitive.
- `dp_rx`  in  1  raw D+ receive value, asynchronous.
- `dn_rx`  in  1  raw D− receive value, asynchronous.
- `tx_active`  in  1  SIE is driving the bus; line monitoring is suspended while high.
- `resume_req`  in  1  one-cycle remote-wakeup request pulse.
- `usb_pullup`  out  1  D+ 1.5 kΩ pull-up enable.
- `drive_k`  out  1  request to the transceiver to drive K (D+=0, D−=1).
- `bus_reset`  out  1  one-cycle pulse per qualified SE0 episode.
- `suspended`  out  1  high while in SUSPENDED.
- `link_state`  out  3  current state encoding.

## Operation
- `dp_rx` and `dn_rx` each pass through a 2-flop synchronizer. Synchronizer flops reset to J (dp=1, dn=0). All decisions use synchronized values.
- Line decode: J=10, K=01, SE0=00, SE1=11. SE1 is non-idle and non-SE0.
- States and encoding: DETACHED=0, ATTACH_WAIT=1, ACTIVE=2, SUSPENDED=3, RESUME_DRIVE=4.
- DETACHED: `usb_pullup`=0. Goes to ATTACH_WAIT when `enable`=1.
- ATTACH_WAIT: `usb_pullup`=0 while counting. After ATTACH_DELAY cycles, goes to ACTIVE.
- ACTIVE: `usb_pullup`=1.
  - `se0_cnt` increments on each SE0 cycle and clears on non-SE0. It saturates at RESET_SE0_CYCLES.
  - `bus_reset` pulses for one cycle in the cycle `se0_cnt` reaches RESET_SE0_CYCLES. It fires exactly once per SE0 episode, however long the episode lasts.
  - `idle_cnt` increments on each J cycle with `tx_active`=0. It clears on any non-J cycle or when `tx_active`=1, and saturates at WAKEUP_MIN_IDLE.
  - Reaching SUSPEND_IDLE_CYCLES moves the state to SUSPENDED.
- SUSPENDED: `suspended`=1; `idle_cnt` keeps counting.
  - Two consecutive non-J synchronized samples (host resume K or reset SE0) return the state to ACTIVE.
  - `se0_cnt` keeps counting across this transition, so a reset that wakes the device still produces `bus_reset`.
- `resume_req` handling:
  - Accepted only in SUSPENDED, where it sets `resume_pending`. Pulses in other states are ignored.
  - While `resume_pending`=1 and `idle_cnt` ≥ WAKEUP_MIN_IDLE, the state moves to RESUME_DRIVE.
  - `resume_pending` clears on entering RESUME_DRIVE or on leaving SUSPENDED by any path.
- RESUME_DRIVE: `drive_k`=1 for RESUME_K_CYCLES. Line inputs are ignored and `se0_cnt`/`idle_cnt` are held at 0. Afterwards the state goes to ACTIVE.
- `tx_active`=1 also holds `se0_cnt` at 0 (the device's own EOP must not count as reset).
- `enable`=0 in any state moves to DETACHED on the next edge. This deasserts `usb_pullup` and `drive_k` and clears counters and `resume_pending`. It has highest priority.
- Counter widths are sized by $clog2 of the largest compared parameter plus 1. All counters saturate and never wrap.

## Timing
- Reset value of every output is 0: `usb_pullup`, `drive_k`, `bus_reset`, `suspended`, `link_state`=DETACHED. Internal counters and `resume_pending` also reset to 0.
- All outputs are registered, and `link_state` and the outputs change on the same edge.
- Pin-to-decision latency is 2 cycles (synchronizer). `bus_reset` asserts on the edge at which the RESET_SE0_CYCLES-th synchronized SE0 cycle is counted.
- `enable` rising → `usb_pullup`=1 after exactly ATTACH_DELAY+1 edges.
- Simultaneous events in SUSPENDED: a non-J wake takes priority over a pending resume, so the state goes to ACTIVE, `drive_k` stays 0 and `resume_pending` clears.
- `rst_n` asserted mid-state forces the reset values immediately (asynchronous). Deassertion is synchronous to `clk48`.

## Test plan
All scenarios use ATTACH_DELAY=16, RESET_SE0_CYCLES=8, SUSPEND_IDLE_CYCLES=32, WAKEUP_MIN_IDLE=40, RESUME_K_CYCLES=10.
- Attach: `rst_n` release with J on the line, `enable`=1 → `link_state` 1 for 16 cycles, then 2 with `usb_pullup`=1. `enable`=0 → `usb_pullup`=0 and state 0 on the next edge.
- Bus reset: in ACTIVE, drive SE0 for 7 cycles → no `bus_reset`. Drive SE0 for 50 cycles → exactly one `bus_reset` pulse, about 10 cycles after SE0 onset. With `tx_active`=1 during 20 cycles of SE0 → no pulse.
- Suspend/host resume: 32 idle J cycles → `suspended`=1, state 3. One K sample → stays suspended. Two K samples → state 2, `suspended`=0.
- Remote wakeup: `resume_req` at idle count 34 → `drive_k` asserts only once the count reaches 40, holds for 10 cycles, then state 2. `resume_req` in ACTIVE → ignored.
- Conflict: `resume_pending` set, then K arrives before idle count 40 → state 2, `drive_k` never asserts.
- Async reset: assert `rst_n` during RESUME_DRIVE → `drive_k`, `usb_pullup` and `link_state` go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/usb_link_ctrl.sv
// USB full-speed link-state controller: attach sequencing, bus reset and
// suspend detection, remote-wakeup K drive.
module usb_link_ctrl #(
   parameter int unsigned ATTACH_DELAY        = 4800,
   parameter int unsigned RESET_SE0_CYCLES    = 120,
   parameter int unsigned SUSPEND_IDLE_CYCLES = 144000,
   parameter int unsigned WAKEUP_MIN_IDLE     = 240000,
   parameter int unsigned RESUME_K_CYCLES     = 48000
) (
   input  logic       clk48,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       dp_rx,
   input  logic       dn_rx,
   input  logic       tx_active,
   input  logic       resume_req,
   output logic       usb_pullup,
   output logic       drive_k,
   output logic       bus_reset,
   output logic       suspended,
   output logic [2:0] link_state
);

   localparam int unsigned M1 =
      (ATTACH_DELAY > RESET_SE0_CYCLES) ? ATTACH_DELAY : RESET_SE0_CYCLES;
   localparam int unsigned M2 =
      (M1 > SUSPEND_IDLE_CYCLES) ? M1 : SUSPEND_IDLE_CYCLES;
   localparam int unsigned M3 =
      (M2 > WAKEUP_MIN_IDLE) ? M2 : WAKEUP_MIN_IDLE;
   localparam int unsigned MX =
      (M3 > RESUME_K_CYCLES) ? M3 : RESUME_K_CYCLES;
   localparam int unsigned CW = $clog2(MX) + 1;

   localparam logic [CW-1:0] R_MAX = CW'(RESET_SE0_CYCLES);
   localparam logic [CW-1:0] S_MAX = CW'(SUSPEND_IDLE_CYCLES);
   localparam logic [CW-1:0] W_MAX = CW'(WAKEUP_MIN_IDLE);
   localparam logic [CW-1:0] A_END = CW'(ATTACH_DELAY - 1);
   localparam logic [CW-1:0] K_END = CW'(RESUME_K_CYCLES - 1);

   typedef enum logic [2:0] {
      DETACHED     = 3'd0,
      ATTACH_WAIT  = 3'd1,
      ACTIVE       = 3'd2,
      SUSPENDED    = 3'd3,
      RESUME_DRIVE = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic          dp_s1_q, dp_s2_q, dn_s1_q, dn_s2_q;
   logic          nj_prev_q;
   logic [CW-1:0] se0_cnt_q, se0_cnt_d, se0_nxt;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d, idle_nxt;
   logic [CW-1:0] tmr_q, tmr_d;
   logic          pend_q, pend_d;
   logic          pullup_q, pullup_d;
   logic          drive_k_q, drive_k_d;
   logic          bus_reset_q, bus_reset_d;
   logic          susp_q, susp_d;
   logic          line_j, line_se0, counting;

   assign line_j   = dp_s2_q & ~dn_s2_q;
   assign line_se0 = ~dp_s2_q & ~dn_s2_q;

   always_comb begin
      se0_nxt     = '0;
      idle_nxt    = '0;
      state_d     = state_q;
      pend_d      = pend_q;
      tmr_d       = '0;
      se0_cnt_d   = '0;
      idle_cnt_d  = '0;
      bus_reset_d = 1'b0;
      counting    = 1'b0;

      if (line_se0 && !tx_active)
         se0_nxt = (se0_cnt_q == R_MAX) ? se0_cnt_q : se0_cnt_q + 1'b1;
      if (line_j && !tx_active)
         idle_nxt = (idle_cnt_q == W_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;

      unique case (state_q)
         DETACHED:
            if (enable) state_d = ATTACH_WAIT;
         ATTACH_WAIT:
            if (tmr_q == A_END) state_d = ACTIVE;
         ACTIVE:
            if (idle_nxt >= S_MAX) state_d = SUSPENDED;
         SUSPENDED: begin
            if (resume_req) pend_d = 1'b1;
            // a host-driven wake beats our own pending resume
            if (!line_j && nj_prev_q)
               state_d = ACTIVE;
            else if (pend_q && idle_cnt_q >= W_MAX)
               state_d = RESUME_DRIVE;
         end
         RESUME_DRIVE:
            if (tmr_q == K_END) state_d = ACTIVE;
         default:
            state_d = DETACHED;
      endcase

      if (!enable) state_d = DETACHED;
      if (state_d != SUSPENDED) pend_d = 1'b0;

      if (state_d == state_q &&
          (state_q == ATTACH_WAIT || state_q == RESUME_DRIVE))
         tmr_d = tmr_q + 1'b1;

      counting = (state_d == ACTIVE) || (state_d == SUSPENDED);
      if (counting) begin
         se0_cnt_d   = se0_nxt;
         idle_cnt_d  = idle_nxt;
         bus_reset_d = (se0_nxt == R_MAX) && (se0_cnt_q != R_MAX);
      end
   end

   assign pullup_d  = (state_d == ACTIVE) || (state_d == SUSPENDED) ||
                      (state_d == RESUME_DRIVE);
   assign drive_k_d = (state_d == RESUME_DRIVE);
   assign susp_d    = (state_d == SUSPENDED);

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         dp_s1_q     <= 1'b1;
         dp_s2_q     <= 1'b1;
         dn_s1_q     <= 1'b0;
         dn_s2_q     <= 1'b0;
         nj_prev_q   <= 1'b0;
         state_q     <= DETACHED;
         se0_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         tmr_q       <= '0;
         pend_q      <= 1'b0;
         pullup_q    <= 1'b0;
         drive_k_q   <= 1'b0;
         bus_reset_q <= 1'b0;
         susp_q      <= 1'b0;
      end else begin
         dp_s1_q     <= dp_rx;
         dp_s2_q     <= dp_s1_q;
         dn_s1_q     <= dn_rx;
         dn_s2_q     <= dn_s1_q;
         nj_prev_q   <= ~line_j;
         state_q     <= state_d;
         se0_cnt_q   <= se0_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         tmr_q       <= tmr_d;
         pend_q      <= pend_d;
         pullup_q    <= pullup_d;
         drive_k_q   <= drive_k_d;
         bus_reset_q <= bus_reset_d;
         susp_q      <= susp_d;
      end
   end

   assign usb_pullup = pullup_q;
   assign drive_k    = drive_k_q;
   assign bus_reset  = bus_reset_q;
   assign suspended  = susp_q;
   assign link_state = state_q;

endmodule

// File: tb/tb_usb_link_ctrl.sv
// Directed bench for usb_link_ctrl with shortened timing parameters.
module tb_usb_link_ctrl;

   logic       clk48 = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       dp_rx;
   logic       dn_rx;
   logic       tx_active;
   logic       resume_req;
   logic       usb_pullup;
   logic       drive_k;
   logic       bus_reset;
   logic       suspended;
   logic [2:0] link_state;

   int checks = 0;
   int errs   = 0;
   int br_n, br_first, dk_n, dk_first;

   always #5 clk48 = ~clk48;

   usb_link_ctrl #(
      .ATTACH_DELAY       (16),
      .RESET_SE0_CYCLES   (8),
      .SUSPEND_IDLE_CYCLES(32),
      .WAKEUP_MIN_IDLE    (40),
      .RESUME_K_CYCLES    (10)
   ) dut (
      .clk48     (clk48),
      .rst_n     (rst_n),
      .enable    (enable),
      .dp_rx     (dp_rx),
      .dn_rx     (dn_rx),
      .tx_active (tx_active),
      .resume_req(resume_req),
      .usb_pullup(usb_pullup),
      .drive_k   (drive_k),
      .bus_reset (bus_reset),
      .suspended (suspended),
      .link_state(link_state)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk48);
         #1;
      end
   endtask

   task automatic line(input logic p, input logic n);
      dp_rx = p;
      dn_rx = n;
   endtask

   task automatic run(input int n, output int bn, output int bf,
                      output int kn, output int kf);
      bn = 0; bf = 0; kn = 0; kf = 0;
      for (int i = 1; i <= n; i++) begin
         tick(1);
         if (bus_reset) begin
            bn++;
            if (bf == 0) bf = i;
         end
         if (drive_k) begin
            kn++;
            if (kf == 0) kf = i;
         end
      end
   endtask

   task automatic pulse_req();
      resume_req = 1'b1;
      tick(1);
      resume_req = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; tx_active = 1'b0; resume_req = 1'b0;
      line(1'b1, 1'b0);
      #23;
      chk("rst_state", int'(link_state), 0);
      chk("rst_pullup", int'(usb_pullup), 0);
      chk("rst_drive_k", int'(drive_k), 0);
      chk("rst_bus_reset", int'(bus_reset), 0);
      chk("rst_suspended", int'(suspended), 0);
      @(posedge clk48); #1;
      rst_n = 1'b1;
      tick(2);

      // attach timing
      enable = 1'b1;
      tick(1);
      chk("attach_first", int'(link_state), 1);
      tick(15);
      chk("attach_16_state", int'(link_state), 1);
      chk("attach_16_pullup", int'(usb_pullup), 0);
      tick(1);
      chk("attach_17_state", int'(link_state), 2);
      chk("attach_17_pullup", int'(usb_pullup), 1);
      line(1'b0, 1'b1);

      enable = 1'b0;
      tick(1);
      chk("detach_state", int'(link_state), 0);
      chk("detach_pullup", int'(usb_pullup), 0);
      enable = 1'b1;
      tick(17);
      chk("reattach_state", int'(link_state), 2);

      // bus reset qualification
      line(1'b0, 1'b0);
      run(7, br_n, br_first, dk_n, dk_first);
      line(1'b0, 1'b1);
      run(5, dk_n, br_first, dk_n, dk_first);
      chk("se0_7_pulses", br_n + dk_n, 0);

      line(1'b0, 1'b0);
      run(50, br_n, br_first, dk_n, dk_first);
      chk("se0_50_pulses", br_n, 1);
      chk("se0_50_onset", br_first, 10);
      line(1'b0, 1'b1);
      tick(5);
      chk("se0_50_state", int'(link_state), 2);

      tx_active = 1'b1;
      line(1'b0, 1'b0);
      run(20, br_n, br_first, dk_n, dk_first);
      tx_active = 1'b0;
      line(1'b0, 1'b1);
      run(5, dk_n, br_first, dk_n, dk_first);
      chk("se0_tx_pulses", br_n + dk_n, 0);

      // suspend and host resume
      line(1'b1, 1'b0);
      tick(33);
      chk("susp_33", int'(suspended), 0);
      tick(1);
      chk("susp_34", int'(suspended), 1);
      chk("susp_34_state", int'(link_state), 3);
      line(1'b0, 1'b1);
      tick(1);
      line(1'b1, 1'b0);
      tick(5);
      chk("one_k_state", int'(link_state), 3);
      line(1'b0, 1'b1);
      tick(3);
      chk("two_k_pre", int'(link_state), 3);
      tick(1);
      chk("two_k_state", int'(link_state), 2);
      chk("two_k_susp", int'(suspended), 0);

      // resume request outside SUSPENDED is dropped
      pulse_req();
      line(1'b1, 1'b0);
      tick(34);
      chk("ign_susp", int'(link_state), 3);
      tick(12);
      chk("ign_state", int'(link_state), 3);
      chk("ign_drive_k", int'(drive_k), 0);
      line(1'b0, 1'b1);
      tick(4);
      chk("ign_wake", int'(link_state), 2);

      // remote wakeup requested at idle count 34
      line(1'b1, 1'b0);
      tick(34);
      chk("rw_susp", int'(link_state), 3);
      tick(2);
      pulse_req();
      run(30, br_n, br_first, dk_n, dk_first);
      chk("rw_k_onset", dk_first, 6);
      chk("rw_k_len", dk_n, 10);
      chk("rw_end_state", int'(link_state), 2);
      line(1'b0, 1'b1);
      tick(3);

      // host K wins over a pending resume
      line(1'b1, 1'b0);
      tick(34);
      chk("cf_susp", int'(link_state), 3);
      tick(1);
      pulse_req();
      line(1'b0, 1'b1);
      run(10, br_n, br_first, dk_n, dk_first);
      chk("cf_drive_k", dk_n, 0);
      chk("cf_state", int'(link_state), 2);
      chk("cf_susp_lo", int'(suspended), 0);

      // asynchronous reset during RESUME_DRIVE
      line(1'b1, 1'b0);
      tick(34);
      chk("ar_susp", int'(link_state), 3);
      tick(6);
      pulse_req();
      for (int i = 0; i < 20 && !drive_k; i++) tick(1);
      chk("ar_in_rd", int'(link_state), 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_drive_k", int'(drive_k), 0);
      chk("ar_pullup", int'(usb_pullup), 0);
      chk("ar_state", int'(link_state), 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule
